id_ex_stage: RTL and testbench

ID/EX pipeline stage of the five-stage RV32I core: it registers the decoded control bundles (`id_ex`, `id_m`, `id_wb`) from the control decoder, together with operands and register indices, and presents them to EX one cycle later. It owns load-use hazard detection and inserts exactly one bubble per load-use hazard. It also squashes its contents on a taken-branch/jump flush and keeps wrapping bubble and flush counters for debug.

---
 rtl/id_ex_stage_pkg.sv | 44 ++++
 rtl/id_ex_stage_load_use_detect.sv | 50 +++++
 rtl/id_ex_stage.sv | 145 ++++++++++++++
 tb/tb_id_ex_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// ============================================================================
//  Module      : id_ex_stage_pkg
//  Description : Shared core definitions for the ID/EX stage: control-bundle
//                widths, bit positions inside the bundles, write-back source
//                codes and a small load-classification helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package id_ex_stage_pkg;

  // Control bundle widths
  localparam int EX_W = 5;   // {alu_src_b, alu_op[3:0]}
  localparam int M_W  = 3;   // {branch, b_type, mem_write}
  localparam int WB_W = 3;   // {reg_write, mem_to_reg[1:0]}

  // Bit positions inside the bundles
  localparam int EX_ALU_SRC_B_BIT = 4;
  localparam int M_BRANCH_BIT     = 2;
  localparam int M_B_TYPE_BIT     = 1;
  localparam int M_MEM_WRITE_BIT  = 0;
  localparam int WB_REG_WRITE_BIT = 2;

  // Write-back source selection (mem_to_reg)
  localparam logic [1:0] MEM_TO_REG_ALU  = 2'b00;
  localparam logic [1:0] MEM_TO_REG_PC4  = 2'b01;
  localparam logic [1:0] MEM_TO_REG_IMM  = 2'b10;
  localparam logic [1:0] MEM_TO_REG_LOAD = 2'b11;

  // Registered control word carried from ID to EX
  typedef struct packed {
    logic [EX_W-1:0] ex;
    logic [M_W-1:0]  m;
    logic [WB_W-1:0] wb;
  } ctrl_t;

  // A WB bundle describes a load when it writes a register from memory.
  function automatic logic wb_is_load(input logic [WB_W-1:0] wb);
    return wb[WB_REG_WRITE_BIT] && (wb[1:0] == MEM_TO_REG_LOAD);
  endfunction

endpackage : id_ex_stage_pkg

`default_nettype wire

// File: rtl/id_ex_stage_load_use_detect.sv
// ============================================================================
//  Module      : load_use_detect
//  Description : Combinational load-use hazard compare. Raises o_stall when
//                the instruction in EX is a load to a non-zero register that
//                the instruction in ID reads. A flush suppresses the stall
//                because the ID instruction is being killed anyway.
//  Ports       : i_ex_valid/i_ex_wb/i_ex_rd   - EX slot state
//                i_id_valid/i_id_rs1/i_id_rs2 - ID slot sources
//                i_id_alu_src_b/i_id_branch/i_id_mem_write - rs2 usage hints
//                i_flush                      - downstream redirect
//                o_stall                      - hold PC and IF/ID this cycle
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic            i_ex_valid,
  input  logic [WB_W-1:0] i_ex_wb,
  input  logic [4:0]      i_ex_rd,
  input  logic            i_id_valid,
  input  logic [4:0]      i_id_rs1,
  input  logic [4:0]      i_id_rs2,
  input  logic            i_id_alu_src_b,
  input  logic            i_id_branch,
  input  logic            i_id_mem_write,
  input  logic            i_flush,
  output logic            o_stall
);

  logic w_ex_is_load;
  logic w_id_uses_rs2;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is never a real destination, so a load to x0 cannot create a hazard.
  assign w_ex_is_load = i_ex_valid & wb_is_load(i_ex_wb) & (i_ex_rd != 5'd0);

  // rs2 is read by register-register ALU ops, stores (data) and branches.
  assign w_id_uses_rs2 = ~i_id_alu_src_b | i_id_mem_write | i_id_branch;

  assign w_rs1_hit = (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = w_id_uses_rs2 & (i_id_rs2 == i_ex_rd);

  assign o_stall = w_ex_is_load & i_id_valid & ~i_flush & (w_rs1_hit | w_rs2_hit);

endmodule : load_use_detect

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register of the five-stage RV32I core.
//                Registers control bundles, operands and register indices,
//                inserts one bubble per load-use hazard, squashes on flush
//                and keeps wrapping bubble/flush debug counters.
//  Ports       : clk, rst_n (async, active low)
//                id_*      - decoded instruction from ID
//                flush     - kill ID/EX contents (taken branch / jump)
//                hold      - global freeze
//                ex_*      - registered instruction presented to EX
//                load_use_stall - combinational stall request to PC/IF-ID
//                bubble_cnt, flush_cnt - debug counters
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [EX_W-1:0]  id_ex,
  input  logic [M_W-1:0]   id_m,
  input  logic [WB_W-1:0]  id_wb,
  input  logic             flush,
  input  logic             hold,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [EX_W-1:0]  ex_ex,
  output logic [M_W-1:0]   ex_m,
  output logic [WB_W-1:0]  ex_wb,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             r_valid;
  ctrl_t            r_ctrl;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_rs1_data;
  logic [XLEN-1:0]  r_rs2_data;
  logic [XLEN-1:0]  r_imm;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_stall;
  ctrl_t            w_id_ctrl;

  load_use_detect u_load_use_detect (
    .i_ex_valid     (r_valid),
    .i_ex_wb        (r_ctrl.wb),
    .i_ex_rd        (r_rd),
    .i_id_valid     (id_valid),
    .i_id_rs1       (id_rs1),
    .i_id_rs2       (id_rs2),
    .i_id_alu_src_b (id_ex[EX_ALU_SRC_B_BIT]),
    .i_id_branch    (id_m[M_BRANCH_BIT]),
    .i_id_mem_write (id_m[M_MEM_WRITE_BIT]),
    .i_flush        (flush),
    .o_stall        (w_stall)
  );

  // An empty ID slot must never carry live control into EX.
  assign w_id_ctrl = id_valid ? ctrl_t'{ex: id_ex, m: id_m, wb: id_wb} : '0;

  // Priority: flush > hold > load-use bubble > normal capture.
  // On flush and bubble only the valid bit and control bundles are cleared;
  // the data registers keep their previous contents since nothing consumes
  // them while ex_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_pc         <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_ctrl      <= '0;
      r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end else if (hold) begin
      // Freeze: every register, including counters, keeps its value.
      r_valid <= r_valid;
    end else if (w_stall) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end else begin
      r_valid    <= id_valid;
      r_ctrl     <= w_id_ctrl;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
    end
  end

  assign ex_valid       = r_valid;
  assign ex_pc          = r_pc;
  assign ex_rs1_data    = r_rs1_data;
  assign ex_rs2_data    = r_rs2_data;
  assign ex_imm         = r_imm;
  assign ex_rs1         = r_rs1;
  assign ex_rs2         = r_rs2;
  assign ex_rd          = r_rd;
  assign ex_ex          = r_ctrl.ex;
  assign ex_m           = r_ctrl.m;
  assign ex_wb          = r_ctrl.wb;
  assign load_use_stall = w_stall;
  assign bubble_cnt     = r_bubble_cnt;
  assign flush_cnt      = r_flush_cnt;

endmodule : id_ex_stage

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage (CNT_W=4 so the bubble
//                counter wraps within a short run).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic [4:0]       id_ex;
  logic [2:0]       id_m, id_wb;
  logic             flush, hold;
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [4:0]       ex_ex;
  logic [2:0]       ex_m, ex_wb;
  logic             load_use_stall;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_ex(id_ex), .id_m(id_m), .id_wb(id_wb),
    .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_ex(ex_ex), .ex_m(ex_m), .ex_wb(ex_wb),
    .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;      // id_valid
    logic [4:0] rs1, rs2, rd;
    logic [4:0] ex;
    logic [2:0] m, wb;
    logic [7:0] imm;
    logic       fl, hd;
    // expected: stall before the edge, then registered state after it
    logic       e_stall, e_valid;
    logic [4:0] e_ex;
    logic [2:0] e_m, e_wb;
    logic [4:0] e_rd, e_rs1, e_rs2;
    logic [7:0] e_imm;
    logic [3:0] e_bub, e_fl;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Operands are derived from imm so the data path is checked as well.
  task automatic drive(input vec_t t);
    id_valid    = t.v;
    id_rs1      = t.rs1;
    id_rs2      = t.rs2;
    id_rd       = t.rd;
    id_ex       = t.ex;
    id_m        = t.m;
    id_wb       = t.wb;
    id_imm      = {24'd0, t.imm};
    id_pc       = {22'd0, t.imm, 2'b00};
    id_rs1_data = 32'hA5A5_0000 | {24'd0, t.imm};
    id_rs2_data = 32'h5A5A_0000 | {24'd0, t.imm};
    flush       = t.fl;
    hold        = t.hd;
  endtask

  task automatic run_vec(input vec_t t, input string name);
    @(negedge clk);
    drive(t);
    #1;
    chk({name, ".stall"}, {31'd0, load_use_stall}, {31'd0, t.e_stall});
    @(posedge clk);
    #1;
    chk({name, ".valid"}, {31'd0, ex_valid}, {31'd0, t.e_valid});
    chk({name, ".ctrl"}, {21'd0, ex_ex, ex_m, ex_wb}, {21'd0, t.e_ex, t.e_m, t.e_wb});
    chk({name, ".idx"}, {17'd0, ex_rd, ex_rs1, ex_rs2}, {17'd0, t.e_rd, t.e_rs1, t.e_rs2});
    chk({name, ".imm"}, ex_imm, {24'd0, t.e_imm});
    chk({name, ".pc"}, ex_pc, {22'd0, t.e_imm, 2'b00});
    chk({name, ".rs1d"}, ex_rs1_data, 32'hA5A5_0000 | {24'd0, t.e_imm});
    chk({name, ".rs2d"}, ex_rs2_data, 32'h5A5A_0000 | {24'd0, t.e_imm});
    chk({name, ".cnt"}, {24'd0, bubble_cnt, flush_cnt}, {24'd0, t.e_bub, t.e_fl});
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".valid"}, {31'd0, ex_valid}, 32'd0);
    chk({name, ".ctrl"}, {21'd0, ex_ex, ex_m, ex_wb}, 32'd0);
    chk({name, ".idx"}, {17'd0, ex_rd, ex_rs1, ex_rs2}, 32'd0);
    chk({name, ".data"}, ex_pc | ex_imm | ex_rs1_data | ex_rs2_data, 32'd0);
    chk({name, ".cnt"}, {24'd0, bubble_cnt, flush_cnt}, 32'd0);
    chk({name, ".stall"}, {31'd0, load_use_stall}, 32'd0);
  endtask

  vec_t lw7, addi7;

  initial begin
    // instruction shapes: addi ex=10000 wb=100; lw ex=10000 wb=111;
    // sw ex=10000 m=001 wb=000; add ex=00000 wb=100; branch m=100
    //           v  rs1   rs2   rd     ex        m      wb      imm    fl hd | st vl  ex        m      wb      rd     rs1   rs2   imm    bub   fl
    tbl[0]  = '{1, 5'd1, 5'd2, 5'd5,  5'b10000, 3'b000, 3'b100, 8'd1,  0, 0,  0, 1, 5'b10000, 3'b000, 3'b100, 5'd5,  5'd1, 5'd2, 8'd1,  4'd0, 4'd0};
    tbl[1]  = '{1, 5'd2, 5'd0, 5'd7,  5'b10000, 3'b000, 3'b111, 8'd2,  0, 0,  0, 1, 5'b10000, 3'b000, 3'b111, 5'd7,  5'd2, 5'd0, 8'd2,  4'd0, 4'd0};
    tbl[2]  = '{1, 5'd7, 5'd0, 5'd8,  5'b10000, 3'b000, 3'b100, 8'd3,  0, 0,  1, 0, 5'b00000, 3'b000, 3'b000, 5'd7,  5'd2, 5'd0, 8'd2,  4'd1, 4'd0};
    tbl[3]  = '{1, 5'd7, 5'd0, 5'd8,  5'b10000, 3'b000, 3'b100, 8'd3,  0, 0,  0, 1, 5'b10000, 3'b000, 3'b100, 5'd8,  5'd7, 5'd0, 8'd3,  4'd1, 4'd0};
    tbl[4]  = '{1, 5'd1, 5'd0, 5'd0,  5'b10000, 3'b000, 3'b111, 8'd4,  0, 0,  0, 1, 5'b10000, 3'b000, 3'b111, 5'd0,  5'd1, 5'd0, 8'd4,  4'd1, 4'd0};
    tbl[5]  = '{1, 5'd0, 5'd0, 5'd9,  5'b00000, 3'b000, 3'b100, 8'd5,  0, 0,  0, 1, 5'b00000, 3'b000, 3'b100, 5'd9,  5'd0, 5'd0, 8'd5,  4'd1, 4'd0};
    tbl[6]  = '{1, 5'd1, 5'd0, 5'd7,  5'b10000, 3'b000, 3'b111, 8'd6,  0, 0,  0, 1, 5'b10000, 3'b000, 3'b111, 5'd7,  5'd1, 5'd0, 8'd6,  4'd1, 4'd0};
    tbl[7]  = '{1, 5'd3, 5'd7, 5'd10, 5'b10000, 3'b000, 3'b100, 8'd7,  0, 0,  0, 1, 5'b10000, 3'b000, 3'b100, 5'd10, 5'd3, 5'd7, 8'd7,  4'd1, 4'd0};
    tbl[8]  = '{1, 5'd1, 5'd0, 5'd7,  5'b10000, 3'b000, 3'b111, 8'd8,  0, 0,  0, 1, 5'b10000, 3'b000, 3'b111, 5'd7,  5'd1, 5'd0, 8'd8,  4'd1, 4'd0};
    tbl[9]  = '{1, 5'd3, 5'd7, 5'd0,  5'b10000, 3'b001, 3'b000, 8'd9,  0, 0,  1, 0, 5'b00000, 3'b000, 3'b000, 5'd7,  5'd1, 5'd0, 8'd8,  4'd2, 4'd0};
    tbl[10] = '{1, 5'd3, 5'd7, 5'd0,  5'b10000, 3'b001, 3'b000, 8'd9,  0, 0,  0, 1, 5'b10000, 3'b001, 3'b000, 5'd0,  5'd3, 5'd7, 8'd9,  4'd2, 4'd0};
    tbl[11] = '{1, 5'd1, 5'd0, 5'd7,  5'b10000, 3'b000, 3'b111, 8'd10, 0, 0,  0, 1, 5'b10000, 3'b000, 3'b111, 5'd7,  5'd1, 5'd0, 8'd10, 4'd2, 4'd0};
    tbl[12] = '{1, 5'd7, 5'd0, 5'd11, 5'b10000, 3'b000, 3'b100, 8'd11, 1, 0,  0, 0, 5'b00000, 3'b000, 3'b000, 5'd7,  5'd1, 5'd0, 8'd10, 4'd2, 4'd1};
    tbl[13] = '{1, 5'd1, 5'd0, 5'd7,  5'b10000, 3'b000, 3'b111, 8'd12, 0, 0,  0, 1, 5'b10000, 3'b000, 3'b111, 5'd7,  5'd1, 5'd0, 8'd12, 4'd2, 4'd1};
    tbl[14] = '{1, 5'd7, 5'd0, 5'd12, 5'b10000, 3'b000, 3'b100, 8'd13, 0, 1,  1, 1, 5'b10000, 3'b000, 3'b111, 5'd7,  5'd1, 5'd0, 8'd12, 4'd2, 4'd1};
    tbl[15] = tbl[14];
    tbl[16] = tbl[14];
    tbl[17] = '{1, 5'd7, 5'd0, 5'd12, 5'b10000, 3'b000, 3'b100, 8'd13, 0, 0,  1, 0, 5'b00000, 3'b000, 3'b000, 5'd7,  5'd1, 5'd0, 8'd12, 4'd3, 4'd1};
    tbl[18] = '{1, 5'd7, 5'd0, 5'd12, 5'b10000, 3'b000, 3'b100, 8'd13, 0, 0,  0, 1, 5'b10000, 3'b000, 3'b100, 5'd12, 5'd7, 5'd0, 8'd13, 4'd3, 4'd1};
    tbl[19] = '{0, 5'd4, 5'd5, 5'd3,  5'b10101, 3'b111, 3'b111, 8'd14, 0, 0,  0, 0, 5'b00000, 3'b000, 3'b000, 5'd3,  5'd4, 5'd5, 8'd14, 4'd3, 4'd1};
    tbl[20] = '{1, 5'd1, 5'd0, 5'd6,  5'b10000, 3'b000, 3'b111, 8'd15, 0, 0,  0, 1, 5'b10000, 3'b000, 3'b111, 5'd6,  5'd1, 5'd0, 8'd15, 4'd3, 4'd1};
    tbl[21] = '{1, 5'd2, 5'd6, 5'd0,  5'b10000, 3'b100, 3'b000, 8'd16, 0, 0,  1, 0, 5'b00000, 3'b000, 3'b000, 5'd6,  5'd1, 5'd0, 8'd15, 4'd4, 4'd1};
    tbl[22] = '{1, 5'd2, 5'd6, 5'd0,  5'b10000, 3'b100, 3'b000, 8'd16, 0, 0,  0, 1, 5'b10000, 3'b100, 3'b000, 5'd0,  5'd2, 5'd6, 8'd16, 4'd4, 4'd1};

    // reset with mid-stream inputs applied
    rst_n = 1'b0;
    drive(tbl[1]);
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++)
      run_vec(tbl[i], $sformatf("vec%0d", i));

    // bubble counter wrap: 4 -> 15 -> 0 over twelve load-use pairs
    lw7   = '{1, 5'd1, 5'd0, 5'd7,  5'b10000, 3'b000, 3'b111, 8'd20, 0, 0,  0, 1, 5'b10000, 3'b000, 3'b111, 5'd7,  5'd1, 5'd0, 8'd20, 4'd0, 4'd1};
    addi7 = '{1, 5'd7, 5'd0, 5'd13, 5'b10000, 3'b000, 3'b100, 8'd21, 0, 0,  1, 0, 5'b00000, 3'b000, 3'b000, 5'd7,  5'd1, 5'd0, 8'd20, 4'd0, 4'd1};
    for (int k = 0; k < 12; k++) begin
      lw7.e_bub = 4'(4 + k);
      run_vec(lw7, $sformatf("wrap%0d.lw", k));
      addi7.e_stall = 1'b1; addi7.e_valid = 1'b0;
      addi7.e_ex = 5'b00000; addi7.e_wb = 3'b000;
      addi7.e_rd = 5'd7; addi7.e_rs1 = 5'd1; addi7.e_imm = 8'd20;
      addi7.e_bub = 4'(5 + k);
      run_vec(addi7, $sformatf("wrap%0d.bub", k));
      addi7.e_stall = 1'b0; addi7.e_valid = 1'b1;
      addi7.e_ex = 5'b10000; addi7.e_wb = 3'b100;
      addi7.e_rd = 5'd13; addi7.e_rs1 = 5'd7; addi7.e_imm = 8'd21;
      run_vec(addi7, $sformatf("wrap%0d.use", k));
    end
    chk("wrap.final", {28'd0, bubble_cnt}, 32'd0);

    // reset asserted while a stall is pending abandons the bubble
    lw7.e_bub = 4'd0;
    run_vec(lw7, "rststall.lw");
    @(negedge clk);
    addi7.fl = 1'b0; addi7.hd = 1'b0;
    drive(addi7);
    #1;
    chk("rststall.pre", {31'd0, load_use_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rststall.in");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all_zero("rststall.out");
    @(posedge clk);
    #1;
    chk("rststall.cap", {31'd0, ex_valid}, 32'd1);
    chk("rststall.rd", {27'd0, ex_rd}, 32'd13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_id_ex_stage

`default_nettype wire
